// File: rtl/reg_operand_seq_pkg.sv
// Shared widths, FSM encoding and the latched request record for the operand sequencer.
// No logic; latency: n/a.
// Backpressure: n/a.
package reg_operand_seq_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 1 << ADDR_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] sr1;
        logic              sr1_en;
        logic [ADDR_W-1:0] sr2;
        logic              sr2_en;
        logic [ADDR_W-1:0] dr;
        logic              dr_en;
    } req_t;
endpackage

// File: rtl/reg_operand_seq_if.sv
// Request, operand-bundle and writeback channels between control/execute and the sequencer.
// Pure wiring; latency: none.
// Backpressure: req_ready/op_ready handshakes; writeback has none.
interface reg_operand_seq_if;
    import reg_operand_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_sr1;
    logic              req_sr1_en;
    logic [ADDR_W-1:0] req_sr2;
    logic              req_sr2_en;
    logic [ADDR_W-1:0] req_dr;
    logic              req_dr_en;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] op_dr;
    logic              op_dr_en;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_unexp;

    modport master (
        output req_valid, req_sr1, req_sr1_en, req_sr2, req_sr2_en, req_dr, req_dr_en,
        input  req_ready,
        input  op_valid, op_a, op_b, op_dr, op_dr_en,
        output op_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_unexp
    );

    modport slave (
        input  req_valid, req_sr1, req_sr1_en, req_sr2, req_sr2_en, req_dr, req_dr_en,
        output req_ready,
        output op_valid, op_a, op_b, op_dr, op_dr_en,
        input  op_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_unexp
    );
endinterface

// File: rtl/reg_file.sv
// 8x16 register file: two combinational read ports, one write port with active-low strobe.
// Latency: reads combinational, write lands at the clock edge.
// Backpressure: none.
module reg_file
    import reg_operand_seq_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] readAddr1,
    input  logic [ADDR_W-1:0] readAddr2,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic              write,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2
);
    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (!write) mem[writeAddr] <= dataIn;
    end

    assign out1 = mem[readAddr1];
    assign out2 = mem[readAddr2];
endmodule

// File: rtl/reg_operand_seq_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue, cleared on writeback, set wins on collision.
// Latency: set/clear visible the cycle after the edge; lookups combinational.
// Backpressure: none.
module reg_scoreboard
    import reg_operand_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] look1_addr,
    input  logic [ADDR_W-1:0] look2_addr,
    output logic              look1_busy,
    output logic              look2_busy,
    output logic [NREG-1:0]   busy
);
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= (busy & ~clr_mask) | set_mask;
    end

    assign look1_busy = busy[look1_addr];
    assign look2_busy = busy[look2_addr];
endmodule

// File: rtl/reg_operand_seq.sv
// Operand sequencer: fetches SR1/SR2 from the register file, stalls on busy sources, commits writebacks.
// Latency: op_valid two edges after req_valid is presented in IDLE (plus stall cycles).
// Backpressure: one request in flight; req_ready low until op bundle is consumed; writebacks never stall.
module reg_operand_seq
    import reg_operand_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    reg_operand_seq_if.slave  sif,
    output logic [ADDR_W-1:0] rf_readAddr1,
    output logic [ADDR_W-1:0] rf_readAddr2,
    output logic [ADDR_W-1:0] rf_writeAddr,
    output logic              rf_write,
    output logic [DATA_W-1:0] rf_in,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2
);
    logic [1:0]        state;
    req_t              lat;
    logic [NREG-1:0]   busy;
    logic              sr1_busy;
    logic              sr2_busy;
    logic              hazard;
    logic              issue;
    logic              wb_fire;
    logic              op_valid_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [ADDR_W-1:0] op_dr_q;
    logic              op_dr_en_q;
    logic              wb_unexp_q;

    assign hazard = (lat.sr1_en & sr1_busy) | (lat.sr2_en & sr2_busy);
    assign issue  = (state == FETCH) & ~hazard;

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (issue & lat.dr_en),
        .set_addr   (lat.dr),
        .clr_en     (sif.wb_valid),
        .clr_addr   (sif.wb_addr),
        .look1_addr (lat.sr1),
        .look2_addr (lat.sr2),
        .look1_busy (sr1_busy),
        .look2_busy (sr2_busy),
        .busy       (busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat        <= '0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_dr_q    <= '0;
            op_dr_en_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (sif.req_valid) begin
                    lat.sr1    <= sif.req_sr1;
                    lat.sr1_en <= sif.req_sr1_en;
                    lat.sr2    <= sif.req_sr2;
                    lat.sr2_en <= sif.req_sr2_en;
                    lat.dr     <= sif.req_dr;
                    lat.dr_en  <= sif.req_dr_en;
                    state      <= FETCH;
                end
                FETCH: if (!hazard) begin
                    op_a_q     <= rf_out1;
                    op_b_q     <= lat.sr2_en ? rf_out2 : '0;
                    op_dr_q    <= lat.dr;
                    op_dr_en_q <= lat.dr_en;
                    op_valid_q <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: if (sif.op_ready) begin
                    op_valid_q <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flag is judged against busy before this edge's own clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wb_unexp_q <= 1'b0;
        else       wb_unexp_q <= sif.wb_valid & ~busy[sif.wb_addr];
    end

    // Writeback path is combinational so the register file updates on the same edge; reset blocks it.
    assign wb_fire      = sif.wb_valid & ~reset;
    assign rf_write     = ~wb_fire;
    assign rf_writeAddr = wb_fire ? sif.wb_addr : '0;
    assign rf_in        = wb_fire ? sif.wb_data : '0;

    assign rf_readAddr1 = lat.sr1;
    assign rf_readAddr2 = lat.sr2;

    assign sif.req_ready = (state == IDLE);
    assign sif.op_valid  = op_valid_q;
    assign sif.op_a      = op_a_q;
    assign sif.op_b      = op_b_q;
    assign sif.op_dr     = op_dr_q;
    assign sif.op_dr_en  = op_dr_en_q;
    assign sif.wb_unexp  = wb_unexp_q;
endmodule

// File: tb/tb_reg_operand_seq.sv
// Bench for reg_operand_seq with the real reg_file: directed scenarios, then randomized ops against a register/busy model.
module tb_reg_operand_seq;
    import reg_operand_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_operand_seq_if sif();
    logic [ADDR_W-1:0] rf_readAddr1, rf_readAddr2, rf_writeAddr;
    logic              rf_write;
    logic [DATA_W-1:0] rf_in, rf_out1, rf_out2;

    reg_operand_seq dut (
        .clk(clk), .reset(reset), .sif(sif),
        .rf_readAddr1(rf_readAddr1), .rf_readAddr2(rf_readAddr2), .rf_writeAddr(rf_writeAddr),
        .rf_write(rf_write), .rf_in(rf_in), .rf_out1(rf_out1), .rf_out2(rf_out2)
    );

    reg_file u_rf (
        .clk(clk), .readAddr1(rf_readAddr1), .readAddr2(rf_readAddr2), .writeAddr(rf_writeAddr),
        .write(rf_write), .dataIn(rf_in), .out1(rf_out1), .out2(rf_out2)
    );

    int total = 0;
    int bad = 0;

    // Reference model: architectural register contents and pending-write set.
    logic [DATA_W-1:0] mregs [NREG];
    logic [NREG-1:0]   mbusy;
    logic              exp_unexp;

    // One clock: drive writeback, advance, then apply the edge to the model (clear first so issue-set wins).
    task automatic step(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic sv, input logic [ADDR_W-1:0] sa);
        sif.wb_valid = wv;
        sif.wb_addr  = wa;
        sif.wb_data  = wd;
        @(posedge clk); #1;
        exp_unexp = wv && !mbusy[wa];
        if (wv) begin
            mregs[wa] = wd;
            mbusy[wa] = 1'b0;
        end
        if (sv) mbusy[sa] = 1'b1;
        sif.wb_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic set_req(input logic [ADDR_W-1:0] s1, input logic e1, input logic [ADDR_W-1:0] s2,
                           input logic e2, input logic [ADDR_W-1:0] d, input logic de);
        sif.req_sr1 = s1; sif.req_sr1_en = e1;
        sif.req_sr2 = s2; sif.req_sr2_en = e2;
        sif.req_dr  = d;  sif.req_dr_en  = de;
    endtask

    // Present a request for one cycle while IDLE.
    task automatic issue_req();
        sif.req_valid = 1'b1;
        idle();
        sif.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++; if (sif.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", sif.req_ready); end
        total++; if (sif.op_valid !== 1'b0) begin bad++; $display("FAIL reset_op_valid got=%b want=0", sif.op_valid); end
        total++; if ({sif.op_a, sif.op_b, sif.op_dr, sif.op_dr_en} !== '0) begin bad++; $display("FAIL reset_op_payload got=%h want=0", {sif.op_a, sif.op_b, sif.op_dr, sif.op_dr_en}); end
        total++; if (sif.wb_unexp !== 1'b0) begin bad++; $display("FAIL reset_wb_unexp got=%b want=0", sif.wb_unexp); end
        total++; if (rf_write !== 1'b1) begin bad++; $display("FAIL reset_rf_write got=%b want=1", rf_write); end
        total++; if ({rf_readAddr1, rf_readAddr2, rf_writeAddr} !== '0) begin bad++; $display("FAIL reset_rf_addr got=%h want=0", {rf_readAddr1, rf_readAddr2, rf_writeAddr}); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (sif.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%b want=1", sif.req_ready); end
    endtask

    task automatic init_regs();
        for (int r = 0; r < NREG; r++) begin
            step(1'b1, ADDR_W'(r), DATA_W'($urandom_range(0, 16'hFFFF)), 1'b0, '0);
            total++; if (sif.wb_unexp !== 1'b1) begin bad++; $display("FAIL init_wb_unexp r=%0d got=%b want=1", r, sif.wb_unexp); end
        end
        idle();
    endtask

    task automatic test_basic();
        sif.op_ready = 1'b1;
        step(1'b1, 3'd3, 16'h1234, 1'b0, '0);
        total++; if (sif.wb_unexp !== exp_unexp) begin bad++; $display("FAIL basic_wb_unexp got=%b want=%b", sif.wb_unexp, exp_unexp); end
        set_req(3'd3, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0);
        issue_req();
        total++; if (sif.op_valid !== 1'b0 || sif.req_ready !== 1'b0) begin bad++; $display("FAIL basic_fetch_cycle got vld=%b rdy=%b want vld=0 rdy=0", sif.op_valid, sif.req_ready); end
        idle();
        total++; if (sif.op_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", sif.op_valid); end
        total++; if (sif.op_a !== 16'h1234 || sif.op_b !== 16'h1234) begin bad++; $display("FAIL basic_operands got a=%h b=%h want 1234/1234", sif.op_a, sif.op_b); end
        idle();
        total++; if (sif.op_valid !== 1'b0 || sif.req_ready !== 1'b1) begin bad++; $display("FAIL basic_consume got vld=%b rdy=%b want 0/1", sif.op_valid, sif.req_ready); end
    endtask

    // Issue a writer of dr through to completion (op_ready assumed high).
    task automatic make_busy(input logic [ADDR_W-1:0] d);
        set_req(3'd0, 1'b0, 3'd0, 1'b0, d, 1'b1);
        issue_req();
        step(1'b0, '0, '0, 1'b1, d);
        idle();
    endtask

    task automatic test_stall();
        make_busy(3'd5);
        set_req(3'd5, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0);
        issue_req();
        for (int i = 0; i < 3; i++) begin
            total++; if (sif.op_valid !== 1'b0) begin bad++; $display("FAIL stall_hold_off cyc=%0d got=%b want=0", i, sif.op_valid); end
            idle();
        end
        step(1'b1, 3'd5, 16'hBEEF, 1'b0, '0);
        total++; if (sif.wb_unexp !== 1'b0) begin bad++; $display("FAIL stall_wb_expected got=%b want=0", sif.wb_unexp); end
        total++; if (sif.op_valid !== 1'b0) begin bad++; $display("FAIL stall_no_forward got=%b want=0", sif.op_valid); end
        idle();
        total++; if (sif.op_valid !== 1'b1 || sif.op_a !== 16'hBEEF) begin bad++; $display("FAIL stall_release got vld=%b a=%h want 1/beef", sif.op_valid, sif.op_a); end
        idle();
    endtask

    task automatic test_imm();
        make_busy(3'd5);
        set_req(3'd1, 1'b1, 3'd5, 1'b0, 3'd4, 1'b0);
        issue_req();
        idle();
        total++; if (sif.op_valid !== 1'b1) begin bad++; $display("FAIL imm_no_stall got=%b want=1", sif.op_valid); end
        total++; if (sif.op_b !== 16'h0000 || sif.op_a !== mregs[1]) begin bad++; $display("FAIL imm_operands got a=%h b=%h want %h/0000", sif.op_a, sif.op_b, mregs[1]); end
        total++; if (sif.op_dr !== 3'd4 || sif.op_dr_en !== 1'b0) begin bad++; $display("FAIL imm_dr got=%0d/%b want 4/0", sif.op_dr, sif.op_dr_en); end
        idle();
    endtask

    task automatic test_hold();
        logic [DATA_W-1:0] ea, eb;
        ea = mregs[2]; eb = mregs[3];
        sif.op_ready = 1'b0;
        set_req(3'd2, 1'b1, 3'd3, 1'b1, 3'd7, 1'b1);
        issue_req();
        step(1'b0, '0, '0, 1'b1, 3'd7);
        for (int i = 0; i < 4; i++) begin
            total++; if (sif.op_valid !== 1'b1 || sif.req_ready !== 1'b0) begin bad++; $display("FAIL hold_handshake cyc=%0d got vld=%b rdy=%b want 1/0", i, sif.op_valid, sif.req_ready); end
            total++; if (sif.op_a !== ea || sif.op_b !== eb || sif.op_dr !== 3'd7) begin bad++; $display("FAIL hold_payload cyc=%0d got %h %h %0d want %h %h 7", i, sif.op_a, sif.op_b, sif.op_dr, ea, eb); end
            idle();
        end
        sif.op_ready = 1'b1;
        idle();
        total++; if (sif.op_valid !== 1'b0 || sif.req_ready !== 1'b1) begin bad++; $display("FAIL hold_release got vld=%b rdy=%b want 0/1", sif.op_valid, sif.req_ready); end
    endtask

    task automatic test_unexp();
        step(1'b1, 3'd2, 16'h0F0F, 1'b0, '0);
        total++; if (sif.wb_unexp !== 1'b1) begin bad++; $display("FAIL unexp_pulse got=%b want=1", sif.wb_unexp); end
        idle();
        total++; if (sif.wb_unexp !== 1'b0) begin bad++; $display("FAIL unexp_one_cycle got=%b want=0", sif.wb_unexp); end
        step(1'b1, 3'd7, 16'h7777, 1'b0, '0);
        total++; if (sif.wb_unexp !== 1'b0) begin bad++; $display("FAIL unexp_busy_r7 got=%b want=0", sif.wb_unexp); end
        set_req(3'd2, 1'b1, 3'd7, 1'b1, 3'd0, 1'b0);
        issue_req();
        idle();
        total++; if (sif.op_a !== 16'h0F0F || sif.op_b !== 16'h7777) begin bad++; $display("FAIL unexp_written got a=%h b=%h want 0f0f/7777", sif.op_a, sif.op_b); end
        idle();
    endtask

    task automatic test_reset_mid();
        sif.op_ready = 1'b0;
        set_req(3'd3, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1);
        issue_req();
        step(1'b0, '0, '0, 1'b1, 3'd5);
        sif.wb_valid = 1'b1; sif.wb_addr = 3'd6; sif.wb_data = 16'hDEAD;
        reset = 1'b1;
        #1;
        total++; if (sif.op_valid !== 1'b0 || sif.req_ready !== 1'b1) begin bad++; $display("FAIL midreset_fsm got vld=%b rdy=%b want 0/1", sif.op_valid, sif.req_ready); end
        total++; if (rf_write !== 1'b1) begin bad++; $display("FAIL midreset_rf_write got=%b want=1", rf_write); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        sif.wb_valid = 1'b0;
        reset = 1'b0;
        mbusy = '0;
        sif.op_ready = 1'b1;
        set_req(3'd5, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0);
        issue_req();
        idle();
        total++; if (sif.op_valid !== 1'b1) begin bad++; $display("FAIL midreset_busy_cleared got=%b want=1", sif.op_valid); end
        total++; if (sif.op_a !== mregs[5] || sif.op_b !== mregs[6]) begin bad++; $display("FAIL midreset_no_write got a=%h b=%h want %h/%h", sif.op_a, sif.op_b, mregs[5], mregs[6]); end
        idle();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] s1, s2, d, wa;
        logic              e1, e2, de, wv, hz;
        logic [DATA_W-1:0] wd, ea, eb;
        int                stall, hold;
        sif.op_ready = 1'b0;
        for (int n = 0; n < 40; n++) begin
            s1 = ADDR_W'($urandom_range(0, NREG-1)); e1 = 1'($urandom_range(0, 1));
            s2 = ADDR_W'($urandom_range(0, NREG-1)); e2 = 1'($urandom_range(0, 1));
            d  = ADDR_W'($urandom_range(0, NREG-1)); de = ($urandom_range(0, 3) != 0);
            total++; if (sif.req_ready !== 1'b1) begin bad++; $display("FAIL rnd_idle_ready n=%0d got=%b want=1", n, sif.req_ready); end
            set_req(s1, e1, s2, e2, d, de);
            sif.req_valid = 1'b1;
            wv = ($urandom_range(0, 3) == 0); wa = ADDR_W'($urandom_range(0, NREG-1)); wd = DATA_W'($urandom);
            step(wv, wa, wd, 1'b0, '0);
            sif.req_valid = 1'b0;
            total++; if (sif.wb_unexp !== exp_unexp) begin bad++; $display("FAIL rnd_wb_unexp n=%0d got=%b want=%b", n, sif.wb_unexp, exp_unexp); end
            stall = 0; hz = 1'b1;
            while (hz && stall < 60) begin
                total++; if (sif.op_valid !== 1'b0) begin bad++; $display("FAIL rnd_fetch_vld n=%0d got=%b want=0", n, sif.op_valid); end
                hz = (e1 && mbusy[s1]) || (e2 && mbusy[s2]);
                if (hz && $urandom_range(0, 1) == 1) begin
                    wv = 1'b1; wa = (e1 && mbusy[s1]) ? s1 : s2;
                end else begin
                    wv = ($urandom_range(0, 3) == 0); wa = ADDR_W'($urandom_range(0, NREG-1));
                end
                wd = DATA_W'($urandom);
                ea = mregs[s1]; eb = e2 ? mregs[s2] : '0;
                step(wv, wa, wd, !hz && de, d);
                total++; if (sif.wb_unexp !== exp_unexp) begin bad++; $display("FAIL rnd_wb_unexp n=%0d got=%b want=%b", n, sif.wb_unexp, exp_unexp); end
                stall++;
            end
            total++; if (hz !== 1'b0) begin bad++; $display("FAIL rnd_stall_bound n=%0d got=%0d cycles want<60", n, stall); end
            hold = $urandom_range(0, 3);
            for (int k = 0; k <= hold; k++) begin
                total++; if (sif.op_valid !== 1'b1 || sif.req_ready !== 1'b0) begin bad++; $display("FAIL rnd_hold_hs n=%0d got vld=%b rdy=%b want 1/0", n, sif.op_valid, sif.req_ready); end
                total++; if (sif.op_a !== ea || sif.op_b !== eb || sif.op_dr !== d || sif.op_dr_en !== de) begin bad++; $display("FAIL rnd_payload n=%0d got %h %h %0d %b want %h %h %0d %b", n, sif.op_a, sif.op_b, sif.op_dr, sif.op_dr_en, ea, eb, d, de); end
                sif.op_ready = (k == hold);
                wv = ($urandom_range(0, 3) == 0); wa = ADDR_W'($urandom_range(0, NREG-1)); wd = DATA_W'($urandom);
                step(wv, wa, wd, 1'b0, '0);
                total++; if (sif.wb_unexp !== exp_unexp) begin bad++; $display("FAIL rnd_wb_unexp n=%0d got=%b want=%b", n, sif.wb_unexp, exp_unexp); end
            end
            sif.op_ready = 1'b0;
            total++; if (sif.op_valid !== 1'b0) begin bad++; $display("FAIL rnd_consume n=%0d got=%b want=0", n, sif.op_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        mbusy = '0;
        exp_unexp = 1'b0;
        sif.req_valid = 1'b0;
        set_req('0, 1'b0, '0, 1'b0, '0, 1'b0);
        sif.op_ready = 1'b0;
        sif.wb_valid = 1'b0; sif.wb_addr = '0; sif.wb_data = '0;
        test_reset();
        init_regs();
        test_basic();
        test_stall();
        test_imm();
        test_hold();
        test_unexp();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
